// File: rtl/fft_mem_ctrl_pkg.sv
// Shared constants, FSM state type and bit-reversal helper for the 32-point FFT memory controller.
package fft_mem_ctrl_pkg;

  localparam int unsigned FFT_N     = 32;
  localparam int unsigned FFT_LOG2N = 5;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned TW_W      = 4;
  localparam int unsigned STAGE_W   = 3;
  localparam int unsigned BFLY_W    = 4;
  localparam int unsigned CNT_W     = 3;

  localparam logic [BFLY_W-1:0]  LAST_BFLY  = BFLY_W'(FFT_N / 2 - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(FFT_LOG2N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Mirror the address bits: MSB becomes LSB.
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(ADDR_W); i++) begin
      r[i] = a[int'(ADDR_W) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address / twiddle index generator for one (stage, butterfly) pair.
// With FFT_BITREV_EN defined, stage-0 read addresses are bit-reversed; natural addresses are always provided.
module fft_addr_gen
  import fft_mem_ctrl_pkg::*;
(
  input  logic [STAGE_W-1:0] stage_i,
  input  logic [BFLY_W-1:0]  bfly_i,
  output logic [ADDR_W-1:0]  nat_1_o,
  output logic [ADDR_W-1:0]  nat_2_o,
  output logic [ADDR_W-1:0]  addr_1_o,
  output logic [ADDR_W-1:0]  addr_2_o,
  output logic [TW_W-1:0]    tw_addr_o
);

  logic [ADDR_W-1:0] b_ext;
  logic [ADDR_W-1:0] half;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] lo;
  logic [ADDR_W-1:0] hi;

  // Group base (b >> s) * 2 * half plus offset inside the group.
  always_comb begin
    b_ext     = ADDR_W'(bfly_i);
    half      = ADDR_W'(1) << stage_i;
    mask      = half - ADDR_W'(1);
    lo        = b_ext & mask;
    hi        = (b_ext >> stage_i) << (stage_i + STAGE_W'(1));
    nat_1_o   = hi | lo;
    nat_2_o   = nat_1_o + half;
    tw_addr_o = TW_W'(lo << (STAGE_W'(FFT_LOG2N - 1) - stage_i));
    addr_1_o  = nat_1_o;
    addr_2_o  = nat_2_o;
`ifdef FFT_BITREV_EN
    if (stage_i == '0) begin
      addr_1_o = bitrev(nat_1_o);
      addr_2_o = bitrev(nat_2_o);
    end
`else
`endif
  end

endmodule

// File: rtl/fft_mem_ctrl.sv
// In-place radix-2 32-point FFT memory controller: issues butterfly addresses, delays them to form writes.
// Optional FFT_BITREV_EN: bit-reversed stage-0 read order (see fft_addr_gen).
module fft_mem_ctrl
  import fft_mem_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               select,
  output logic               write_enable,
  output logic [ADDR_W-1:0]  addr_1,
  output logic [ADDR_W-1:0]  addr_2,
  output logic [ADDR_W-1:0]  addw_1,
  output logic [ADDR_W-1:0]  addw_2,
  output logic [TW_W-1:0]    tw_addr,
  output logic [STAGE_W-1:0] stage
);

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [BFLY_W-1:0]  bfly_q, bfly_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               issue_v_q, issue_v_d;
  logic [ADDR_W-1:0]  addr1_q, addr1_d, addr2_q, addr2_d;
  logic [ADDR_W-1:0]  nat1_q, nat1_d, nat2_q, nat2_d;
  logic [TW_W-1:0]    tw_q, tw_d;

  logic [ADDR_W-1:0]  gen_nat_1, gen_nat_2, gen_addr_1, gen_addr_2;
  logic [TW_W-1:0]    gen_tw;

  logic               pipe_v_q  [PIPE_LAT];
  logic [ADDR_W-1:0]  pipe_a1_q [PIPE_LAT];
  logic [ADDR_W-1:0]  pipe_a2_q [PIPE_LAT];

  // Addresses are generated for the next cycle's butterfly so they leave the block registered.
  fft_addr_gen u_addr_gen (
    .stage_i   (stage_d),
    .bfly_i    (bfly_d),
    .nat_1_o   (gen_nat_1),
    .nat_2_o   (gen_nat_2),
    .addr_1_o  (gen_addr_1),
    .addr_2_o  (gen_addr_2),
    .tw_addr_o (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      bfly_q    <= '0;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      issue_v_q <= 1'b0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      nat1_q    <= '0;
      nat2_q    <= '0;
      tw_q      <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      bfly_q    <= bfly_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      issue_v_q <= issue_v_d;
      addr1_q   <= addr1_d;
      addr2_q   <= addr2_d;
      nat1_q    <= nat1_d;
      nat2_q    <= nat2_d;
      tw_q      <= tw_d;
    end
  end

  // Write-back delay line: natural-order addresses trail the reads by PIPE_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        pipe_v_q[i]  <= 1'b0;
        pipe_a1_q[i] <= '0;
        pipe_a2_q[i] <= '0;
      end
    end else begin
      pipe_v_q[0]  <= issue_v_q;
      pipe_a1_q[0] <= nat1_q;
      pipe_a2_q[0] <= nat2_q;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        pipe_v_q[i]  <= pipe_v_q[i-1];
        pipe_a1_q[i] <= pipe_a1_q[i-1];
        pipe_a2_q[i] <= pipe_a2_q[i-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          stage_d = '0;
          bfly_d  = '0;
          sel_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        bfly_d = bfly_q + BFLY_W'(1);
        if (bfly_q == LAST_BFLY) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Leaving DRAIN only after PIPE_LAT cycles guarantees the stage's last write has landed.
        if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
          if (stage_q == LAST_STAGE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + STAGE_W'(1);
            bfly_d  = '0;
            sel_d   = ~sel_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next-cycle registered output values derived from the next state.
  always_comb begin
    issue_v_d = (state_d == ST_ISSUE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    addr1_d   = '0;
    addr2_d   = '0;
    nat1_d    = '0;
    nat2_d    = '0;
    tw_d      = '0;
    if (issue_v_d) begin
      addr1_d = gen_addr_1;
      addr2_d = gen_addr_2;
      nat1_d  = gen_nat_1;
      nat2_d  = gen_nat_2;
      tw_d    = gen_tw;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign select       = sel_q;
  assign stage        = stage_q;
  assign addr_1       = addr1_q;
  assign addr_2       = addr2_q;
  assign tw_addr      = tw_q;
  assign write_enable = pipe_v_q[PIPE_LAT-1];
  assign addw_1       = pipe_a1_q[PIPE_LAT-1];
  assign addw_2       = pipe_a2_q[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// Directed self-checking bench for fft_mem_ctrl (PIPE_LAT=4); outputs sampled on the falling edge.
module tb_fft_mem_ctrl;

  localparam int unsigned PL    = 4;
  localparam int          TOTAL = 5 * (16 + PL) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, select, write_enable;
  logic [4:0] addr_1, addr_2, addw_1, addw_2;
  logic [3:0] tw_addr;
  logic [2:0] stage;

  int vectors     = 0;
  int miscompares = 0;

  logic [4:0] e1  [5][16];
  logic [4:0] e2  [5][16];
  logic [3:0] etw [5][16];

  fft_mem_ctrl #(.PIPE_LAT(PL)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .select       (select),
    .write_enable (write_enable),
    .addr_1       (addr_1),
    .addr_2       (addr_2),
    .addw_1       (addw_1),
    .addw_2       (addw_2),
    .tw_addr      (tw_addr),
    .stage        (stage)
  );

  always #5 clk = ~clk;

  // Expected butterflies enumerated group by group, offset j inside each group.
  task automatic build_tables();
    for (int s = 0; s < 5; s++) begin
      int half;
      int b;
      half = 1 << s;
      b = 0;
      for (int g = 0; g < (16 / half); g++) begin
        for (int j = 0; j < half; j++) begin
          e1[s][b]  = 5'(g * 2 * half + j);
          e2[s][b]  = 5'(g * 2 * half + j + half);
          etw[s][b] = 4'(j * (16 / half));
          b++;
        end
      end
    end
  endtask

  function automatic logic [4:0] rev5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  function automatic logic [4:0] rd_exp(input int s, input logic [4:0] a);
`ifdef FFT_BITREV_EN
    if (s == 0) return rev5(a);
`endif
    return a;
  endfunction

  // Leaves the bench at the falling edge of cycle 1 (start sampled in cycle 0).
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, write_enable, select, stage} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got busy/done/we/sel/stage=%b, want 0", {busy, done, write_enable, select, stage});
    end
    vectors++;
    if ({addr_1, addr_2, addw_1, addw_2, tw_addr} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h %h %h %h %h, want all 0", addr_1, addr_2, addw_1, addw_2, tw_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int ndone;
    ndone = 0;
    start_pulse();
    for (int c = 1; c <= TOTAL + 3; c++) begin
      logic eb, ed;
      eb = (c <= TOTAL);
      ed = (c == TOTAL);
      if (done === 1'b1) ndone++;
      vectors++;
      if ({busy, done} !== {eb, ed}) begin
        miscompares++;
        $display("FAIL latency c=%0d: busy/done=%b%b, want %b%b", c, busy, done, eb, ed);
      end
      @(negedge clk);
    end
    vectors++;
    if (ndone != 1) begin
      miscompares++;
      $display("FAIL done_count: got %0d pulses, want 1", ndone);
    end
  endtask

  task automatic test_addressing();
    int nwe [5];
    for (int s = 0; s < 5; s++) nwe[s] = 0;
    start_pulse();
    for (int c = 1; c <= TOTAL + 3; c++) begin
      if (c < TOTAL) begin
        int s, r;
        s = (c - 1) / 20;
        r = (c - 1) % 20;
        vectors++;
        if ({select, stage} !== {1'(s % 2), 3'(s)}) begin
          miscompares++;
          $display("FAIL sel_stage c=%0d: sel=%b stage=%0d, want sel=%0d stage=%0d", c, select, stage, s % 2, s);
        end
        if (r < 16) begin
          vectors++;
          if ({addr_1, addr_2, tw_addr} !== {rd_exp(s, e1[s][r]), rd_exp(s, e2[s][r]), etw[s][r]}) begin
            miscompares++;
            $display("FAIL rd_addr s=%0d b=%0d: got %0d/%0d tw %0d, want %0d/%0d tw %0d", s, r,
                     addr_1, addr_2, tw_addr, rd_exp(s, e1[s][r]), rd_exp(s, e2[s][r]), etw[s][r]);
          end
        end
        vectors++;
        if (write_enable !== (r >= 4)) begin
          miscompares++;
          $display("FAIL we c=%0d: got %b, want %b", c, write_enable, (r >= 4));
        end
        if (write_enable === 1'b1) nwe[s]++;
        if (r >= 4) begin
          vectors++;
          if ({addw_1, addw_2} !== {e1[s][r-4], e2[s][r-4]}) begin
            miscompares++;
            $display("FAIL wr_addr s=%0d b=%0d: got %0d/%0d, want %0d/%0d", s, r - 4, addw_1, addw_2,
                     e1[s][r-4], e2[s][r-4]);
          end
        end
      end else begin
        vectors++;
        if ({write_enable, addr_1, addr_2, addw_1, addw_2, tw_addr, select} !== 26'd0) begin
          miscompares++;
          $display("FAIL idle_zero c=%0d: we=%b a=%0d/%0d w=%0d/%0d tw=%0d sel=%b, want all 0", c,
                   write_enable, addr_1, addr_2, addw_1, addw_2, tw_addr, select);
        end
      end
      // Hand-computed anchor points.
      if (c == 1) begin
        vectors++;
        if ({addr_1, addr_2, tw_addr} !== {rd_exp(0, 5'd0), rd_exp(0, 5'd1), 4'd0}) begin
          miscompares++;
          $display("FAIL s0b0: got %0d/%0d tw %0d", addr_1, addr_2, tw_addr);
        end
      end
`ifdef FFT_BITREV_EN
      if (c == 2) begin
        vectors++;
        if ({addr_1, addr_2} !== {5'd8, 5'd24}) begin
          miscompares++;
          $display("FAIL s0b1_rev: got %0d/%0d, want 8/24", addr_1, addr_2);
        end
      end
      if (c == 6) begin
        vectors++;
        if ({write_enable, addw_1, addw_2} !== {1'b1, 5'd2, 5'd3}) begin
          miscompares++;
          $display("FAIL s0b1_wr: got we=%b %0d/%0d, want 1 2/3", write_enable, addw_1, addw_2);
        end
      end
`endif
      if (c == 46) begin
        vectors++;
        if ({addr_1, addr_2, tw_addr} !== {5'd9, 5'd13, 4'd4}) begin
          miscompares++;
          $display("FAIL s2b5: got %0d/%0d tw %0d, want 9/13 tw 4", addr_1, addr_2, tw_addr);
        end
      end
      if (c == 50) begin
        vectors++;
        if ({write_enable, addw_1, addw_2} !== {1'b1, 5'd9, 5'd13}) begin
          miscompares++;
          $display("FAIL s2b5_wr: got we=%b %0d/%0d, want 1 9/13", write_enable, addw_1, addw_2);
        end
      end
      if (c == 84) begin
        vectors++;
        if ({addr_1, addr_2, tw_addr} !== {5'd3, 5'd19, 4'd3}) begin
          miscompares++;
          $display("FAIL s4b3: got %0d/%0d tw %0d, want 3/19 tw 3", addr_1, addr_2, tw_addr);
        end
      end
      if (c == 88) begin
        vectors++;
        if ({write_enable, addw_1, addw_2} !== {1'b1, 5'd3, 5'd19}) begin
          miscompares++;
          $display("FAIL s4b3_wr: got we=%b %0d/%0d, want 1 3/19", write_enable, addw_1, addw_2);
        end
      end
      @(negedge clk);
    end
    for (int s = 0; s < 5; s++) begin
      vectors++;
      if (nwe[s] != 16) begin
        miscompares++;
        $display("FAIL we_count s=%0d: got %0d, want 16", s, nwe[s]);
      end
    end
  endtask

  task automatic test_start_held();
    int ndone_first;
    int waited;
    ndone_first = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 2 * TOTAL + 3; c++) begin
      if (c < 2 * TOTAL && done === 1'b1) ndone_first++;
      if (c == TOTAL) begin
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL held_done1: got %b, want 1", done); end
      end
      if (c == TOTAL + 1) begin
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL held_idle: busy=%b, want 0", busy); end
      end
      if (c == TOTAL + 2) begin
        vectors++;
        if ({busy, stage, select} !== 5'b1_000_0) begin
          miscompares++;
          $display("FAIL held_restart: busy/stage/sel=%b, want 1_000_0", {busy, stage, select});
        end
      end
      if (c == 2 * TOTAL + 1) begin
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL held_done2: got %b, want 1", done); end
      end
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (ndone_first != 1) begin
      miscompares++;
      $display("FAIL held_count: got %0d done pulses before restart finished, want 1", ndone_first);
    end
    waited = 0;
    while (busy !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL held_timeout: busy=%b after %0d cycles, want 0", busy, waited);
    end
  endtask

  task automatic test_reset_mid();
    int nbad;
    nbad = 0;
    start_pulse();
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, write_enable} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_abort: busy/done/we=%b, want 000", {busy, done, write_enable});
    end
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_priority: busy=%b, want 0", busy);
    end
    for (int c = 0; c < 120; c++) begin
      if ({busy, done, write_enable} !== 3'b000) nbad++;
      @(negedge clk);
    end
    vectors++;
    if (nbad != 0) begin
      miscompares++;
      $display("FAIL rst_quiet: %0d active cycles after reset, want 0", nbad);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    build_tables();
    test_reset();
    test_latency();
    test_addressing();
    test_start_held();
    test_reset_mid();
    test_latency();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_mem_ctrl.md
FFT_MEM_CTRL -- requirements
Module: fft_mem_ctrl

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 4, meaning cycles from read address presented to memory until the matching butterfly results are valid at din_1/din_2 (legal range 2..8).
REQ-002 SHALL have ports: clk  input  1  clock; rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start  input  1  begin one 32-point transform; busy  output  1  transform in progress; done  output  1  one-cycle completion pulse.
REQ-004 SHALL have ports: select  output  1  bank select, 1 = write bank A and read bank B; write_enable  output  1  write strobe.
REQ-005 SHALL have ports: addr_1, addr_2  output  5  read addresses; addw_1, addw_2  output  5  write addresses.
REQ-006 SHALL have ports: tw_addr  output  4  twiddle ROM index, aligned with addr_1/addr_2; stage  output  3  current stage 0..4.

Function
REQ-007 SHALL run FSM IDLE -> ISSUE -> DRAIN -> (ISSUE for next stage | DONE) -> IDLE.
REQ-008 SHALL leave IDLE only on start=1, entering ISSUE next cycle with stage=0, butterfly counter b=0.
REQ-009 SHALL ignore start outside IDLE.
REQ-010 ISSUE SHALL last 16 cycles, one butterfly per cycle, b = 0..15.
REQ-011 Addressing, stage s: half = 1<<s; addr_1 = (b>>s)*2*half + (b & (half-1)); addr_2 = addr_1 + half; tw_addr = (b & (half-1)) << (4-s); all arithmetic modulo 5/4-bit widths.
REQ-012 SHALL delay each issued address pair through a PIPE_LAT-deep valid/address shift register; write_enable = tail valid, addw_1/addw_2 = tail addresses.
REQ-013 DRAIN SHALL last exactly PIPE_LAT cycles, so the last write of a stage occurs in the final DRAIN cycle and the next stage reads only committed data.
REQ-014 select SHALL be 0 in stage 0 and toggle at each ISSUE entry of a new stage (stages 0,2,4 = 0; 1,3 = 1); constant throughout ISSUE and DRAIN of a stage.
REQ-015 After stage 4 DRAIN, SHALL enter DONE for one cycle with done=1, then IDLE.
REQ-016 Total latency: start sampled in cycle 0 -> done high in cycle 5*(16+PIPE_LAT)+1.
REQ-017 busy SHALL be 1 in ISSUE, DRAIN, DONE; 0 in IDLE.
REQ-018 In IDLE: write_enable=0, addr/addw/tw_addr=0; select holds last value.

Reset
REQ-019 On rst=1 at a clock edge: state=IDLE, stage=0, b=0, pipeline valids cleared, select=0, busy=0, done=0, write_enable=0, all addresses 0, from the following cycle.
REQ-020 rst mid-transform SHALL abort with no further write strobes; rst has priority over start.

Configuration
REQ-021 Macro FFT_BITREV_EN: defined -> stage-0 addr_1/addr_2 are the 5-bit bit-reversal of the REQ-011 values, addw unchanged (natural order); undefined -> no reversal in any stage.

Structure
REQ-022 Shared package SHALL hold FFT_N=32, FFT_LOG2N=5, address width 5, twiddle width 4, FSM state typedef.
REQ-023 One sub-module fft_addr_gen (combinational stage/b -> addr_1, addr_2, tw_addr, bit-reversal option) is natural; pipeline and FSM stay in top.

Verification
REQ-024 Reset then start pulse, PIPE_LAT=4 -> busy from cycle 1, done single pulse at cycle 101, busy low cycle 102.
REQ-025 Stage 0 b=0 -> addr 0/1, tw 0; stage 2 b=5 -> addr 9/13, tw 4; stage 4 b=3 -> addr 3/19, tw 3; each write_enable with same addw exactly 4 cycles later.
REQ-026 select sequence across stages = 0,1,0,1,0; 16 write strobes per stage, none during ISSUE's first PIPE_LAT cycles of the following stage overlap with previous stage.
REQ-027 rst asserted at cycle 30 -> from cycle 31 write_enable=0, busy=0, no done; new start runs full 101-cycle transform.
REQ-028 start held high through a transform -> exactly one transform, second begins only from IDLE; with FFT_BITREV_EN stage 0 b=1 -> addr 8/24, addw 2/3.
